// File: rtl/intbus_master.sv
// intbus_master: single-outstanding initiator for the internal register bus.
// A command is taken on a valid/ready port, turned into exactly one bus
// strobe, and its outcome is returned on a valid/ready response port. Reads
// wait for the responder's rvalid, up to TIMEOUT cycles.
module intbus_master #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              resetn,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // intbus master side
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wr,
  output logic              bus_rd,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // The counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q,   err_d;

  // Next-state and datapath updates for the command/response sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error without touching the bus.
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (we_q) begin
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // rvalid is checked first so it wins over an expiring counter.
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end
        // Saturating increment: the counter never wraps back to zero.
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registered state, so they drop with reset.
  always_comb begin
    cmd_ready = resetn && (state_q == IDLE);
    busy      = (state_q != IDLE);
    bus_wr    = (state_q == ISSUE) &&  we_q;
    bus_rd    = (state_q == ISSUE) && !we_q;
    bus_addr  = addr_q;
    bus_wdata = wdata_q;
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule

// File: tb/tb_intbus_master.sv
// Testbench for intbus_master: directed command sequences with literal
// expectations, plus a transaction-level timing model compared every cycle.
module tb_intbus_master;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          TIMEOUT  = 64;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wr;
  logic              bus_rd;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  intbus_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .ERR_DATA(ERR_DATA)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_rdata (bus_rdata),
    .bus_rvalid(bus_rvalid),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model: remembers the accepted command and its accept cycle t,
  // and derives from the timing rules when the strobe and the response appear.
  // ---------------------------------------------------------------------------
  bit          m_active;
  int          m_t;
  bit          m_we;
  bit          m_mis;
  int          m_resp_at;
  logic [31:0] m_rdata;
  bit          m_err;
  logic [31:0] m_last_addr;
  logic [31:0] m_last_wdata;

  initial begin
    bit exp_strobe;
    bit exp_rv;
    m_active     = 1'b0;
    m_t          = 0;
    m_we         = 1'b0;
    m_mis        = 1'b0;
    m_resp_at    = -1;
    m_rdata      = '0;
    m_err        = 1'b0;
    m_last_addr  = '0;
    m_last_wdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        check("m_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("m_rst_busy",      32'(busy),      32'd0);
        check("m_rst_bus_wr",    32'(bus_wr),    32'd0);
        check("m_rst_bus_rd",    32'(bus_rd),    32'd0);
        check("m_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("m_rst_rsp_err",   32'(rsp_err),   32'd0);
        check("m_rst_rsp_rdata", rsp_rdata,      32'd0);
        check("m_rst_bus_addr",  bus_addr,       32'd0);
        check("m_rst_bus_wdata", bus_wdata,      32'd0);
        m_active     = 1'b0;
        m_resp_at    = -1;
        m_last_addr  = '0;
        m_last_wdata = '0;
      end else begin
        exp_strobe = m_active && !m_mis && (cyc == m_t + 1);
        exp_rv     = m_active && (m_resp_at >= 0) && (cyc >= m_resp_at);
        check("m_cmd_ready", 32'(cmd_ready), 32'(!m_active));
        check("m_busy",      32'(busy),      32'(m_active));
        check("m_bus_wr",    32'(bus_wr),    32'(exp_strobe && m_we));
        check("m_bus_rd",    32'(bus_rd),    32'(exp_strobe && !m_we));
        check("m_bus_addr",  bus_addr,       m_last_addr);
        check("m_bus_wdata", bus_wdata,      m_last_wdata);
        check("m_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
          check("m_rsp_rdata", rsp_rdata,    m_rdata);
          check("m_rsp_err",   32'(rsp_err), 32'(m_err));
        end
        // A read resolves on the first rvalid inside its listening window,
        // or errors on the window's last cycle.
        if (m_active && !m_mis && !m_we && (m_resp_at < 0)) begin
          if (bus_rvalid && (cyc >= m_t + 2)) begin
            m_resp_at = cyc + 1;
            m_rdata   = bus_rdata;
            m_err     = 1'b0;
          end else if (cyc == m_t + 1 + TIMEOUT) begin
            m_resp_at = cyc + 1;
            m_rdata   = ERR_DATA;
            m_err     = 1'b1;
          end
        end
        // Handshakes that complete at the coming edge.
        if (m_active) begin
          if (exp_rv && rsp_ready) m_active = 1'b0;
        end else if (cmd_valid) begin
          m_active     = 1'b1;
          m_t          = cyc;
          m_we         = cmd_we;
          m_mis        = (cmd_addr[1:0] != 2'b00);
          m_last_addr  = cmd_addr;
          m_last_wdata = cmd_wdata;
          if (m_mis) begin
            m_resp_at = cyc + 1;
            m_rdata   = ERR_DATA;
            m_err     = 1'b1;
          end else if (cmd_we) begin
            m_resp_at = cyc + 2;
            m_rdata   = '0;
            m_err     = 1'b0;
          end else begin
            m_resp_at = -1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus; inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int k);
    repeat (k) step();
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) step();
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int n);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    n         = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;

    // Reset values while reset is held.
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_bus_addr",  bus_addr,       32'd0);
    step();
    resetn = 1'b1;
    step();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_busy",      32'(busy),      32'd0);

    // Write: strobe at N+1, response at N+2.
    send_cmd(1'b1, 32'h40000004, 32'h12345678, n);
    check("wr_strobe",    32'(bus_wr),    32'd1);
    check("wr_no_rd",     32'(bus_rd),    32'd0);
    check("wr_addr",      bus_addr,       32'h40000004);
    check("wr_data",      bus_wdata,      32'h12345678);
    check("wr_rv_early",  32'(rsp_valid), 32'd0);
    step();
    check("wr_strobe_off", 32'(bus_wr),    32'd0);
    check("wr_rsp_valid",  32'(rsp_valid), 32'd1);
    check("wr_rsp_err",    32'(rsp_err),   32'd0);
    check("wr_rsp_rdata",  rsp_rdata,      32'd0);
    ack();

    // Read: rvalid two cycles after the strobe.
    send_cmd(1'b0, 32'h40000004, 32'h0, n);
    check("rd_strobe", 32'(bus_rd), 32'd1);
    check("rd_no_wr",  32'(bus_wr), 32'd0);
    step_n(2);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h12345678;
    check("rd_rv_early", 32'(rsp_valid), 32'd0);
    step();
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", rsp_rdata,      32'h12345678);
    check("rd_rsp_err",   32'(rsp_err),   32'd0);
    ack();

    // Read: earliest rvalid, one cycle after the strobe.
    send_cmd(1'b0, 32'h40000020, 32'h0, n);
    step();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0A0B0C0D;
    step();
    bus_rvalid = 1'b0;
    check("rd_fast_valid", 32'(rsp_valid), 32'd1);
    check("rd_fast_rdata", rsp_rdata,      32'h0A0B0C0D);
    ack();

    // Read timeout: no responder, response at N+2+TIMEOUT.
    send_cmd(1'b0, 32'h40000008, 32'h0, n);
    wait_cycle(n + 1 + TIMEOUT);
    check("to_rv_early", 32'(rsp_valid), 32'd0);
    check("to_busy",     32'(busy),      32'd1);
    step();
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err",   32'(rsp_err),   32'd1);
    check("to_rsp_rdata", rsp_rdata,      32'hDEADBEEF);
    ack();
    // Late stray rvalid after the timeout must be ignored.
    wait_cycle(n + 71);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hBAD0BAD0;
    step();
    bus_rvalid = 1'b0;
    check("stray_busy",  32'(busy),      32'd0);
    check("stray_valid", 32'(rsp_valid), 32'd0);
    send_cmd(1'b0, 32'h4000000C, 32'h0, n);
    step();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5A5A1234;
    step();
    bus_rvalid = 1'b0;
    check("after_to_rdata", rsp_rdata,    32'h5A5A1234);
    check("after_to_err",   32'(rsp_err), 32'd0);
    ack();

    // rvalid on the very last cycle of the window wins over the timeout.
    send_cmd(1'b0, 32'h40000010, 32'h0, n);
    wait_cycle(n + 1 + TIMEOUT);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h13572468;
    step();
    bus_rvalid = 1'b0;
    check("edge_rsp_valid", 32'(rsp_valid), 32'd1);
    check("edge_rsp_err",   32'(rsp_err),   32'd0);
    check("edge_rsp_rdata", rsp_rdata,      32'h13572468);
    ack();

    // Reset while waiting for read data.
    send_cmd(1'b0, 32'h40000018, 32'h0, n);
    step_n(2);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_bus_rd",    32'(bus_rd),    32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_bus_addr",  bus_addr,       32'd0);
    check("mid_rst_rsp_rdata", rsp_rdata,      32'd0);
    step_n(2);
    resetn = 1'b1;
    step();
    send_cmd(1'b0, 32'h40000018, 32'h0, n);
    step();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h2468ACE0;
    step();
    bus_rvalid = 1'b0;
    check("post_mid_rst_rdata", rsp_rdata,    32'h2468ACE0);
    check("post_mid_rst_err",   32'(rsp_err), 32'd0);
    ack();

    // Misaligned command: immediate error, no strobe; then a held response
    // with the next command already waiting.
    send_cmd(1'b1, 32'h40000002, 32'hFFFFFFFF, n);
    check("mis_no_wr",     32'(bus_wr),    32'd0);
    check("mis_no_rd",     32'(bus_rd),    32'd0);
    check("mis_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mis_rsp_err",   32'(rsp_err),   32'd1);
    check("mis_rsp_rdata", rsp_rdata,      32'hDEADBEEF);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 32'h40000014;
    cmd_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 10; i++) begin
      bus_rvalid = (i == 4);
      bus_rdata  = 32'h77777777;
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    bus_rvalid = 1'b0;
    check("hold_rdata", rsp_rdata,    32'hDEADBEEF);
    check("hold_err",   32'(rsp_err), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("next_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("next_wr",    32'(bus_wr), 32'd1);
    check("next_addr",  bus_addr,    32'h40000014);
    check("next_wdata", bus_wdata,   32'hA5A5A5A5);
    step();
    check("next_rsp_valid", 32'(rsp_valid), 32'd1);
    check("next_rsp_rdata", rsp_rdata,      32'd0);
    ack();

    // Back-to-back writes at one command per three cycles.
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_cmd(1'b1, 32'h40000100 + 32'(4 * k), 32'h00001000 + 32'(k), n);
      check("b2b_wr", 32'(bus_wr), 32'd1);
      step();
      check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
      step();
      check("b2b_idle", 32'(cmd_ready), 32'd1);
    end
    rsp_ready = 1'b0;

    step_n(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
